// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Receives a valid/ready byte stream, assembles little-endian 32-bit words,
// writes them to the instruction memory and keeps the core held until the
// image is complete.
//
// Stream layout: 4-byte word count N, then N program words.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing 4-byte
// checksum (mod-2^32 sum of the program words) checked in state CHK.
//
// state | meaning
// IDLE  | after reset, waiting for Start, core held
// HDR   | collecting the 4-byte word count
// LOAD  | collecting program words, one write per completed word
// CHK   | collecting the checksum (checksum build only)
// DONE  | image loaded, core released
// ERR   | session aborted, core held, no writes
module imem_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic        ByteValid,
    input  logic [7:0]  ByteData,
    output logic        ByteReady,
    output logic        WE,
    output logic [31:0] WA,
    output logic [31:0] WD,
    output logic        CpuHold,
    output logic        Done,
    output logic        Err,
    output logic [31:0] LoadCnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LOAD = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        S_CHK  = 3'd5
`endif
    } state_t;

    state_t      r_state;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_word;        // lower three bytes of the word being assembled
    logic [31:0] r_hdr_n;
    logic        r_ready;
    logic        r_we;
    logic [31:0] r_wa;
    logic [31:0] r_wd;
    logic        r_hold;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_load_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_csum;
`endif

    logic        w_xfer;
    logic        w_word_end;
    logic [31:0] w_full;
    logic        w_last_word;
    logic [31:0] w_waddr;
    logic        w_restart;

    assign w_xfer      = ByteValid && r_ready;
    assign w_word_end  = w_xfer && (r_byte_idx == 2'd3);
    // The 4th byte completes the word straight from the input bus.
    assign w_full      = {ByteData, r_word};
    // LoadCnt equals the index of the word being assembled: the previous
    // word's write always lands before the next word can complete.
    assign w_last_word = ((r_load_cnt + 32'd1) == r_hdr_n);
    assign w_waddr     = BASE_ADDR + (r_load_cnt << 2);
    assign w_restart   = Start &&
                         ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

    // Loader FSM with registered handshake, write-port and status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_byte_idx <= 2'd0;
            r_word     <= 24'd0;
            r_hdr_n    <= 32'd0;
            r_ready    <= 1'b0;
            r_we       <= 1'b0;
            r_wa       <= BASE_ADDR;
            r_wd       <= 32'd0;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_load_cnt <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= 32'd0;
`endif
        end else begin
            r_we <= 1'b0;

            if (w_xfer) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0:    r_word[7:0]   <= ByteData;
                    2'd1:    r_word[15:8]  <= ByteData;
                    2'd2:    r_word[23:16] <= ByteData;
                    default: r_word        <= r_word;
                endcase
            end

            if (w_restart) begin
                // New session: everything from the previous one is dropped,
                // memory contents are left alone.
                r_state    <= S_HDR;
                r_ready    <= 1'b1;
                r_hold     <= 1'b1;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
                r_load_cnt <= 32'd0;
                r_byte_idx <= 2'd0;
                r_word     <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_csum     <= 32'd0;
`endif
            end else begin
                case (r_state)
                    S_HDR: begin
                        if (w_word_end) begin
                            r_hdr_n <= w_full;
                            if (w_full == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                // Empty image still carries a (zero) checksum.
                                r_state <= S_CHK;
`else
                                r_state <= S_DONE;
                                r_ready <= 1'b0;
                                r_done  <= 1'b1;
                                r_hold  <= 1'b0;
`endif
                            end else if (w_full > 32'(DEPTH)) begin
                                r_state <= S_ERR;
                                r_ready <= 1'b0;
                                r_err   <= 1'b1;
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end
                    end

                    S_LOAD: begin
                        if (w_word_end) begin
                            r_we       <= 1'b1;
                            r_wa       <= w_waddr;
                            r_wd       <= w_full;
                            r_load_cnt <= r_load_cnt + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_csum     <= r_csum + w_full;
`endif
                            if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                r_state <= S_CHK;
`else
                                r_state <= S_DONE;
                                r_ready <= 1'b0;
                                r_done  <= 1'b1;
                                r_hold  <= 1'b0;
`endif
                            end
                        end
                    end

`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CHK: begin
                        if (w_word_end) begin
                            r_ready <= 1'b0;
                            if (w_full == r_csum) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_hold  <= 1'b0;
                            end else begin
                                r_state <= S_ERR;
                                r_err   <= 1'b1;
                            end
                        end
                    end
`endif

                    S_IDLE, S_DONE, S_ERR: begin
                        r_ready <= 1'b0;
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b0;
                        r_hold  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign ByteReady = r_ready;
    assign WE        = r_we;
    assign WA        = r_wa;
    assign WD        = r_wd;
    assign CpuHold   = r_hold;
    assign Done      = r_done;
    assign Err       = r_err;
    assign LoadCnt   = r_load_cnt;

endmodule
